// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin sharing of one FIFO write port among N_REQ
// requesters, with full back-pressure and a MAX_BURST word limit per tenure.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | no owner, grant=0; any pending req is arbitrated from rr_ptr
//   S_OWN  | grant=onehot(owner); owner's words pass straight to the FIFO
module fifo_write_arbiter #(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] data_in,
  input  logic                   fifo_full,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       ack,
  output logic                   write_to_FIFO,
  output logic [WIDTH-1:0]       data_to_FIFO,
  output logic                   busy
);

  localparam int OW = $clog2(N_REQ);

  typedef enum logic {S_IDLE, S_OWN} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [N_REQ-1:0] r_grant;
  logic [N_REQ-1:0] w_grant_nxt;
  logic [OW-1:0]    r_owner;
  logic [OW-1:0]    w_owner_nxt;
  logic [OW-1:0]    r_rr_ptr;
  logic [OW-1:0]    w_rr_ptr_nxt;
  logic [3:0]       r_burst_cnt;
  logic [3:0]       w_burst_nxt;

  logic [OW-1:0]    w_owner_inc;
  logic [OW-1:0]    w_start;
  logic [OW-1:0]    w_pick;
  logic             w_found;
  int               w_idx;
  logic [N_REQ-1:0] w_ack;
  logic             w_write;
  logic [WIDTH-1:0] w_owner_data;
  logic             w_release;

  // Write path: the owner's word goes through whenever the FIFO has room.
  // Reset also blocks the strobe so nothing is written in a reset cycle.
  always_comb begin
    w_ack        = r_grant & req & {N_REQ{~fifo_full & ~reset}};
    w_write      = |w_ack;
    w_owner_data = data_in[r_owner*WIDTH +: WIDTH];
  end

  // Rotating search: from rr_ptr when idle, from owner+1 (owner last) when owning.
  always_comb begin
    w_owner_inc = (r_owner == OW'(N_REQ-1)) ? '0 : r_owner + 1'b1;
    w_start     = (r_state == S_OWN) ? w_owner_inc : r_rr_ptr;
    w_found     = 1'b0;
    w_pick      = '0;
    w_idx       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = int'(w_start) + k;
      if (w_idx >= N_REQ) w_idx = w_idx - N_REQ;
      if (!w_found && req[OW'(w_idx)]) begin
        w_found = 1'b1;
        w_pick  = OW'(w_idx);
      end
    end
  end

  // Next-state: arbitration in idle, tenure counting and release while owning.
  always_comb begin
    w_state_nxt  = r_state;
    w_owner_nxt  = r_owner;
    w_rr_ptr_nxt = r_rr_ptr;
    w_burst_nxt  = r_burst_cnt;
    w_release    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt = S_OWN;
          w_owner_nxt = w_pick;
          w_burst_nxt = '0;
        end
      end
      S_OWN: begin
        w_release = ~req[r_owner] |
                    (w_ack[r_owner] & (r_burst_cnt == 4'(MAX_BURST-1)));
        if (w_ack[r_owner]) w_burst_nxt = r_burst_cnt + 4'd1;
        if (w_release) begin
          w_rr_ptr_nxt = w_owner_inc;
          w_burst_nxt  = '0;
          if (w_found) begin
            w_owner_nxt = w_pick;
          end else begin
            w_state_nxt = S_IDLE;
            w_owner_nxt = '0;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_grant_nxt = '0;
    if (w_state_nxt == S_OWN) w_grant_nxt[w_owner_nxt] = 1'b1;
  end

  // State register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_grant     <= '0;
      r_owner     <= '0;
      r_rr_ptr    <= '0;
      r_burst_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_grant     <= w_grant_nxt;
      r_owner     <= w_owner_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_burst_cnt <= w_burst_nxt;
    end
  end

  assign grant         = r_grant;
  assign ack           = w_ack;
  assign write_to_FIFO = w_write;
  assign data_to_FIFO  = w_write ? w_owner_data : '0;
  assign busy          = |r_grant;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: directed scenarios plus a random run, all
// compared every cycle against a queue/index-level ownership model.
module tb_fifo_write_arbiter;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int MB = 4;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] data_in = '0;
  logic           fifo_full = 1'b0;
  logic [N-1:0]   grant;
  logic [N-1:0]   ack;
  logic           write_to_FIFO;
  logic [W-1:0]   data_to_FIFO;
  logic           busy;

  fifo_write_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
    .clock(clock), .reset(reset), .req(req), .data_in(data_in),
    .fifo_full(fifo_full), .grant(grant), .ack(ack),
    .write_to_FIFO(write_to_FIFO), .data_to_FIFO(data_to_FIFO), .busy(busy)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  bit [N-1:0] want;
  bit         full_w;
  bit         rst_w;
  bit         chk_en = 0;
  bit         pending[N];
  int         seq[N];
  int         sb_seq[N];
  int         waits[N];
  int         m_own = -1;
  int         m_rr  = 0;
  int         m_cnt = 0;
  int         ten_words = 0;
  int         wr_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int search(input int start);
    for (int k = 0; k < N; k++) begin
      if (req[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  task automatic start_tenure(input int w);
    for (int i = 0; i < N; i++) begin
      if (i != w && req[i]) begin
        waits[i]++;
        chk($sformatf("wait_bound_r%0d", i), 64'(waits[i] > N-1), 0);
      end
    end
    waits[w]  = 0;
    m_own     = w;
    m_cnt     = 0;
    ten_words = 0;
  endtask

  // Compare DUT outputs with the model for the current cycle, then advance the model.
  task automatic model_cycle();
    logic [N-1:0] e_grant;
    logic [N-1:0] e_ack;
    logic         e_wr;
    logic [W-1:0] e_data;
    bit           rel;
    int           nxt;
    int           r;
    e_grant = (m_own >= 0) ? N'(1 << m_own) : '0;
    e_ack   = '0;
    if (m_own >= 0 && req[m_own] && !fifo_full && !reset) e_ack[m_own] = 1'b1;
    e_wr    = |e_ack;
    e_data  = e_wr ? data_in[m_own*W +: W] : '0;

    chk("grant", grant, e_grant);
    chk("ack", ack, e_ack);
    chk("write", write_to_FIFO, e_wr);
    chk("data", data_to_FIFO, e_data);
    chk("busy", busy, 64'(m_own >= 0));
    chk("onehot", 64'($countones(grant) <= 1), 1);

    if (write_to_FIFO) begin
      wr_cnt++;
      ten_words++;
      chk("tenure_len", 64'(ten_words <= MB), 1);
      r = int'(data_to_FIFO[31:24]);
      chk("write_src", 64'(r < N), 1);
      if (r < N) begin
        chk($sformatf("order_r%0d", r), data_to_FIFO[23:0], sb_seq[r][23:0]);
        sb_seq[r]++;
      end
    end

    for (int i = 0; i < N; i++) begin
      if (e_ack[i]) begin
        pending[i] = 0;
        seq[i]++;
      end
      if (!req[i]) waits[i] = 0;
    end

    if (reset) begin
      m_own = -1; m_rr = 0; m_cnt = 0; ten_words = 0;
      for (int i = 0; i < N; i++) waits[i] = 0;
    end else if (m_own < 0) begin
      nxt = search(m_rr);
      if (nxt >= 0) start_tenure(nxt);
    end else begin
      rel = !req[m_own] || (e_ack[m_own] && m_cnt == MB-1);
      if (e_ack[m_own]) m_cnt++;
      if (rel) begin
        m_rr = (m_own + 1) % N;
        nxt  = search(m_own + 1);
        if (nxt >= 0) start_tenure(nxt);
        else m_own = -1;
      end
    end
  endtask

  // One clock cycle: requesters present/hold words, then the cycle is checked.
  task automatic step();
    @(posedge clock);
    #1;
    reset     = rst_w;
    fifo_full = full_w;
    for (int i = 0; i < N; i++) begin
      if (!pending[i] && want[i]) pending[i] = 1;
      req[i] = pending[i];
      data_in[i*W +: W] = {8'(i), 24'(seq[i])};
    end
    @(negedge clock);
    if (chk_en) model_cycle();
  endtask

  task automatic do_reset();
    rst_w = 1; step(); rst_w = 0;
  endtask

  task automatic drain(input int n);
    want = '0; full_w = 0;
    repeat (n) step();
  endtask

  initial begin
    int base;
    logic [N-1:0] gseq[$];
    logic [N-1:0] last_g;
    int gaps;
    want = '0; full_w = 0; rst_w = 1;
    for (int i = 0; i < N; i++) begin
      pending[i] = 0; seq[i] = 0; sb_seq[i] = 0; waits[i] = 0;
    end
    step(); step();
    chk_en = 1;
    step();
    rst_w = 0;

    // 1: idle with no requests, then reset in the middle of a tenure
    base = wr_cnt;
    repeat (10) step();
    chk("idle_writes", 64'(wr_cnt - base), 0);
    chk("idle_busy", busy, 0);
    want = 4'b0010;
    step();
    step();
    chk("t1_grant_own", grant, 4'b0010);
    rst_w = 1;
    step();
    chk("t1_rst_ack", ack, 4'b0000);
    chk("t1_rst_wr", write_to_FIFO, 0);
    rst_w = 0; want = '0;
    step();
    chk("t1_after_rst_grant", grant, 4'b0000);
    drain(10);

    // 2: single requester, continuous writes across re-granted tenures
    seq[2] = 32'hA0; sb_seq[2] = 32'hA0;
    do_reset();
    base = wr_cnt;
    want = 4'b0100;
    step();
    chk("t2_arb_grant", grant, 4'b0000);
    chk("t2_arb_wr", write_to_FIFO, 0);
    step();
    chk("t2_grant", grant, 4'b0100);
    chk("t2_data0", data_to_FIFO, 32'h0200_00A0);
    step();
    chk("t2_data1", data_to_FIFO, 32'h0200_00A1);
    repeat (7) step();
    chk("t2_writes", 64'(wr_cnt - base), 9);
    chk("t2_grant_end", grant, 4'b0100);
    drain(10);

    // 3: all requesting, rotation with zero-cycle handover
    do_reset();
    want = 4'b1111;
    step();
    last_g = '0; gaps = 0;
    repeat (17) begin
      step();
      if (!write_to_FIFO) gaps++;
      if (grant != last_g) begin
        gseq.push_back(grant);
        last_g = grant;
      end
    end
    chk("t3_ntenures", 64'(gseq.size()), 5);
    if (gseq.size() >= 5) begin
      chk("t3_g0", gseq[0], 4'b0001);
      chk("t3_g1", gseq[1], 4'b0010);
      chk("t3_g2", gseq[2], 4'b0100);
      chk("t3_g3", gseq[3], 4'b1000);
      chk("t3_g4", gseq[4], 4'b0001);
    end
    chk("t3_gaps", 64'(gaps), 0);
    drain(30);

    // 4: FIFO full mid-tenure freezes the word count and holds the grant
    do_reset();
    want = 4'b0010;
    step(); step(); step();
    want = 4'b1010; full_w = 1;
    base = wr_cnt;
    repeat (5) begin
      step();
      chk("t4_full_grant", grant, 4'b0010);
      chk("t4_full_wr", write_to_FIFO, 0);
    end
    chk("t4_full_writes", 64'(wr_cnt - base), 0);
    full_w = 0;
    step();
    chk("t4_w3", data_to_FIFO[31:24], 1);
    step();
    chk("t4_w4", data_to_FIFO[31:24], 1);
    step();
    chk("t4_handover", grant, 4'b1000);
    drain(30);

    // 5: owner drops after one word; later search restarts from index 0
    do_reset();
    want = 4'b1001;
    step();
    step();
    chk("t5_own0", grant, 4'b0001);
    chk("t5_wr0", write_to_FIFO, 1);
    want = 4'b1000;
    step();
    chk("t5_drop_wr", write_to_FIFO, 0);
    step();
    chk("t5_grant3", grant, 4'b1000);
    want = '0;
    step();
    want = 4'b1010;
    step();
    chk("t5_idle", grant, 4'b0000);
    step();
    chk("t5_rr0", grant, 4'b0010);
    drain(30);

    // 6: random requests and back-pressure
    repeat (2000) begin
      want   = N'($urandom);
      full_w = ($urandom_range(0, 3) == 0);
      step();
    end
    drain(100);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("drain_pending_r%0d", i), 64'(pending[i]), 0);
      chk($sformatf("no_loss_r%0d", i), 64'(sb_seq[i]), 64'(seq[i]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
